multiplier_pipe: RTL and testbench

Parametrised, stallable 3-stage integer multiplier for the ALU execute path. Successor to the fixed 16-bit unsigned-saturating multiplier. Adds:
- configurable operand width and partial-product grouping;
- four result modes (unsigned/signed saturate, low-half wrap, high half);
- overflow flag, pipeline stall and flush, asynchronous reset.

Instruction words travel alongside the data so the ALU can track occupancy and retire results.

---
 rtl/multiplier_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_multiplier_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_pipe.sv
// ---------------------------------------------------------------------------
// multiplier_pipe
//   Stallable, flushable integer multiplier for the ALU execute path.
//   The pipeline is issue -> m2 -> ex. The m2 register holds GROUP-bit
//   partial products of the operand magnitudes. The ex register holds the
//   full, signed-corrected 2*WIDTH product. Result selection and saturation
//   are combinational from the ex register.
//
// Parameters
//   WIDTH   operand / result width (>= 4)
//   GROUP   multiplier (B) bits folded into one partial product; must divide WIDTH
//   INSTR_W instruction tag width; an all-zero tag is a bubble
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   instr        issuing instruction tag (nonzero = valid op)
//   mode         00 unsigned sat, 01 signed sat, 10 low-half wrap, 11 unsigned high half
//   A, B         multiplicand / multiplier
//   stall        hold every pipeline register this cycle
//   flush        kill in-flight ops (wins over stall)
//   product      result of the op in ex (0 for a bubble)
//   ovf          result was clamped or truncated
//   mul_status   {m2 occupied, ex occupied}
//   ex_instr_out tag of the op in ex
// ---------------------------------------------------------------------------

// One partial product: a * b_grp, as a shift-and-add over the GROUP bits.
module multiplier_pipe_pp #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic [WIDTH-1:0]       a,
   input  logic [GROUP-1:0]       b_grp,
   output logic [WIDTH+GROUP-1:0] pp
);
   always_comb begin
      pp = '0;
      for (int j = 0; j < GROUP; j++) begin
         if (b_grp[j]) pp = pp + ({{GROUP{1'b0}}, a} << j);
      end
   end
endmodule

module multiplier_pipe #(
   parameter int WIDTH   = 16,
   parameter int GROUP   = 4,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic               stall,
   input  logic               flush,
   output logic [WIDTH-1:0]   product,
   output logic               ovf,
   output logic [1:0]         mul_status,
   output logic [INSTR_W-1:0] ex_instr_out
);

   localparam int NPP    = WIDTH / GROUP;
   localparam int PPW    = WIDTH + GROUP;
   localparam int PW     = 2 * WIDTH;
   localparam int STAGES = 2;

   localparam logic [1:0] MODE_USAT = 2'b00;
   localparam logic [1:0] MODE_SSAT = 2'b01;
   localparam logic [1:0] MODE_WRAP = 2'b10;
   localparam logic [1:0] MODE_HIGH = 2'b11;

   generate
      if (WIDTH % GROUP != 0) begin : g_bad_group
         $error("multiplier_pipe: WIDTH must be a multiple of GROUP");
      end
      if (WIDTH < 4) begin : g_bad_width
         $error("multiplier_pipe: WIDTH must be at least 4");
      end
   endgenerate

   typedef struct packed {
      logic [INSTR_W-1:0]        instr;
      logic [1:0]                mode;
      logic                      neg;   // product must be negated in m2->ex
      logic [NPP-1:0][PPW-1:0]   pp;
   } m2_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [1:0]         mode;
      logic [PW-1:0]      p;
   } ex_t;

   m2_t               m2_q, m2_d;
   ex_t               ex_q, ex_d;
   // vld_pipe[1] = m2 occupied, vld_pipe[2] = ex occupied
   logic [STAGES:1]   vld_pipe;

   // ---------------- issue stage: magnitudes + partial products -----------
   logic                    signed_op;
   logic [WIDTH-1:0]        a_mag, b_mag;
   logic [NPP-1:0][PPW-1:0] pp_s1;

   // In signed mode the partial products work on |A| and |B|. The sign is
   // carried separately. |min| is 2^(WIDTH-1), which still fits as unsigned.
   always_comb begin
      signed_op = (mode == MODE_SSAT);
      a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
      b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
   end

   genvar k;
   generate
      for (k = 0; k < NPP; k++) begin : g_pp
         multiplier_pipe_pp #(.WIDTH(WIDTH), .GROUP(GROUP)) u_pp (
            .a     (a_mag),
            .b_grp (b_mag[k*GROUP +: GROUP]),
            .pp    (pp_s1[k])
         );
      end
   endgenerate

   always_comb begin
      m2_d.instr = instr;
      m2_d.mode  = mode;
      m2_d.neg   = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
      m2_d.pp    = pp_s1;
   end

   // ---------------- m2 stage: reduce and apply sign ----------------------
   logic [PW-1:0] p_sum;

   always_comb begin
      p_sum = '0;
      for (int i = 0; i < NPP; i++) begin
         p_sum = p_sum + (PW'(m2_q.pp[i]) << (i * GROUP));
      end
      ex_d.instr = m2_q.instr;
      ex_d.mode  = m2_q.mode;
      ex_d.p     = m2_q.neg ? -p_sum : p_sum;
   end

   // ---------------- pipeline registers -----------------------------------
   // Flush clears only the occupancy (tags and valids). The data registers
   // keep their contents because nothing reads them for a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m2_q     <= '0;
         ex_q     <= '0;
         vld_pipe <= '0;
      end else if (flush) begin
         m2_q.instr <= '0;
         ex_q.instr <= '0;
         vld_pipe   <= '0;
      end else if (!stall) begin
         m2_q     <= m2_d;
         ex_q     <= ex_d;
         vld_pipe <= {vld_pipe[1], |instr};
      end
   end

   // ---------------- ex stage: result selection ---------------------------
   logic [WIDTH-1:0] p_hi, p_lo;
   logic [WIDTH:0]   p_top;     // bits that must all match for a signed fit
   logic [WIDTH-1:0] sel_p;
   logic             sel_ovf;

   always_comb begin
      p_hi    = ex_q.p[PW-1:WIDTH];
      p_lo    = ex_q.p[WIDTH-1:0];
      p_top   = ex_q.p[PW-1:WIDTH-1];
      sel_p   = p_lo;
      sel_ovf = 1'b0;
      case (ex_q.mode)
         MODE_USAT: begin
            if (|p_hi) begin
               sel_p   = '1;
               sel_ovf = 1'b1;
            end
         end
         MODE_SSAT: begin
            if (!((&p_top) || !(|p_top))) begin
               sel_ovf = 1'b1;
               sel_p   = ex_q.p[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
         MODE_WRAP: sel_ovf = |p_hi;
         MODE_HIGH: sel_p   = p_hi;
         default:   sel_p   = p_lo;
      endcase
   end

   always_comb begin
      product      = vld_pipe[2] ? sel_p : '0;
      ovf          = vld_pipe[2] & sel_ovf;
      mul_status   = {vld_pipe[1], vld_pipe[2]};
      ex_instr_out = ex_q.instr;
   end

endmodule

// File: tb/tb_multiplier_pipe.sv
// Bench for multiplier_pipe. It runs the default 16/4 configuration plus
// 8/2 and 32/8 variants on shared stimulus. Each DUT sees the operands
// truncated to its own width.
module tb_multiplier_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic [1:0]  mode;
   logic [31:0] a_in, b_in;
   logic        stall, flush;

   logic [7:0]  p8;  logic o8;  logic [1:0] s8;  logic [15:0] t8;
   logic [15:0] p16; logic o16; logic [1:0] s16; logic [15:0] t16;
   logic [31:0] p32; logic o32; logic [1:0] s32; logic [15:0] t32;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multiplier_pipe #(.WIDTH(16), .GROUP(4), .INSTR_W(16)) u16 (
      .clk(clk), .rst(rst), .instr(instr), .mode(mode), .A(a_in[15:0]), .B(b_in[15:0]),
      .stall(stall), .flush(flush), .product(p16), .ovf(o16), .mul_status(s16),
      .ex_instr_out(t16));

   multiplier_pipe #(.WIDTH(8), .GROUP(2), .INSTR_W(16)) u8 (
      .clk(clk), .rst(rst), .instr(instr), .mode(mode), .A(a_in[7:0]), .B(b_in[7:0]),
      .stall(stall), .flush(flush), .product(p8), .ovf(o8), .mul_status(s8),
      .ex_instr_out(t8));

   multiplier_pipe #(.WIDTH(32), .GROUP(8), .INSTR_W(16)) u32 (
      .clk(clk), .rst(rst), .instr(instr), .mode(mode), .A(a_in), .B(b_in),
      .stall(stall), .flush(flush), .product(p32), .ovf(o32), .mul_status(s32),
      .ex_instr_out(t32));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] t, input logic [1:0] m,
                        input logic [15:0] a, input logic [15:0] b);
      instr = t; mode = m; a_in = {16'h0, a}; b_in = {16'h0, b};
   endtask

   // Arithmetic reference: plain integer multiply, then the mode's clamp.
   function automatic void ref_mul(input int w, input logic [1:0] md,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] p, output logic o);
      longint unsigned mask, am, bm, up;
      longint sa, sb, sp, smax, smin;
      mask = (64'd1 << w) - 64'd1;
      am = longint'(a) & mask;
      bm = longint'(b) & mask;
      sa = am[w-1] ? longint'(am) - longint'(64'd1 << w) : longint'(am);
      sb = bm[w-1] ? longint'(bm) - longint'(64'd1 << w) : longint'(bm);
      up = am * bm;
      sp = sa * sb;
      smax = (longint'(1) << (w-1)) - 1;
      smin = -(longint'(1) << (w-1));
      o = 1'b0;
      case (md)
         2'b00: if (up > mask) begin p = 32'(mask); o = 1'b1; end
                else p = 32'(up);
         2'b01: if (sp > smax) begin p = 32'(smax); o = 1'b1; end
                else if (sp < smin) begin p = 32'(64'd1 << (w-1)); o = 1'b1; end
                else p = 32'(longint'(sp) & longint'(mask));
         2'b10: begin p = 32'(up & mask); o = ((up >> w) != 0); end
         default: p = 32'(up >> w);
      endcase
   endfunction

   task automatic test_reset();
      if (p16 !== 16'h0 || o16 !== 1'b0 || s16 !== 2'b00 || t16 !== 16'h0)
         begin n_fail++; $display("FAIL reset_init: got p=%h ovf=%b st=%b tag=%h expected 0", p16, o16, s16, t16); end
      n_tests++;
      tick();
      rst = 1'b0;
      drive(16'h0011, 2'b00, 16'h0003, 16'h0005); tick();
      drive(16'h0022, 2'b00, 16'h0007, 16'h0007); tick();
      if (s16 !== 2'b11 || p16 !== 16'd15 || t16 !== 16'h0011)
         begin n_fail++; $display("FAIL reset_prefill: got st=%b p=%h tag=%h expected st=11 p=000f tag=0011", s16, p16, t16); end
      n_tests++;
      drive(16'h0, 2'b00, 16'h0, 16'h0);
      #2 rst = 1'b1;
      #1;
      if (p16 !== 16'h0 || o16 !== 1'b0 || s16 !== 2'b00 || t16 !== 16'h0)
         begin n_fail++; $display("FAIL reset_async: got p=%h ovf=%b st=%b tag=%h expected 0", p16, o16, s16, t16); end
      n_tests++;
      tick();
      rst = 1'b0;
      drive(16'h0033, 2'b10, 16'h0002, 16'h0002); tick();
      if (s16 !== 2'b10 || t16 !== 16'h0 || p16 !== 16'h0)
         begin n_fail++; $display("FAIL reset_first_op: got st=%b tag=%h p=%h expected st=10 tag=0 p=0", s16, t16, p16); end
      n_tests++;
      drive(16'h0, 2'b00, 16'h0, 16'h0); tick();
      if (s16 !== 2'b01 || t16 !== 16'h0033 || p16 !== 16'h0004)
         begin n_fail++; $display("FAIL reset_no_stale: got st=%b tag=%h p=%h expected st=01 tag=0033 p=0004", s16, t16, p16); end
      n_tests++;
      tick();
   endtask

   // Back-to-back directed vectors on the 16-bit DUT. The first check also
   // confirms that nothing reaches ex after a single edge.
   task automatic test_unsigned_sat();
      logic [15:0] va[2] = '{16'h00FF, 16'h0100};
      logic [15:0] vb[2] = '{16'h0101, 16'h0100};
      logic [15:0] vp[2] = '{16'hFFFF, 16'hFFFF};
      logic        vo[2] = '{1'b0, 1'b1};
      for (int i = 0; i <= 2; i++) begin
         if (i < 2) drive(16'h0100 + 16'(i), 2'b00, va[i], vb[i]);
         else       drive(16'h0, 2'b00, 16'h0, 16'h0);
         tick();
         if (i == 0) begin
            if (s16 !== 2'b10)
               begin n_fail++; $display("FAIL usat_latency: got st=%b expected 10", s16); end
            n_tests++;
         end else begin
            if (p16 !== vp[i-1] || o16 !== vo[i-1] || t16 !== 16'h0100 + 16'(i-1))
               begin n_fail++; $display("FAIL usat_%0d: got p=%h ovf=%b tag=%h expected p=%h ovf=%b", i-1, p16, o16, t16, vp[i-1], vo[i-1]); end
            n_tests++;
         end
      end
      tick();
   endtask

   task automatic test_signed_sat();
      logic [15:0] va[3] = '{16'hFFFE, 16'h8000, 16'h4000};
      logic [15:0] vb[3] = '{16'h0003, 16'hFFFF, 16'h0004};
      logic [15:0] vp[3] = '{16'hFFFA, 16'h7FFF, 16'h7FFF};
      logic        vo[3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i <= 3; i++) begin
         if (i < 3) drive(16'h0200 + 16'(i), 2'b01, va[i], vb[i]);
         else       drive(16'h0, 2'b00, 16'h0, 16'h0);
         tick();
         if (i > 0) begin
            if (p16 !== vp[i-1] || o16 !== vo[i-1] || t16 !== 16'h0200 + 16'(i-1))
               begin n_fail++; $display("FAIL ssat_%0d: got p=%h ovf=%b tag=%h expected p=%h ovf=%b", i-1, p16, o16, t16, vp[i-1], vo[i-1]); end
            n_tests++;
         end
      end
      tick();
   endtask

   // Same operands, mode flips between consecutive ops.
   task automatic test_wrap_high();
      logic [1:0]  vm[2] = '{2'b10, 2'b11};
      logic [15:0] vp[2] = '{16'h0060, 16'h0626};
      logic        vo[2] = '{1'b1, 1'b0};
      for (int i = 0; i <= 2; i++) begin
         if (i < 2) drive(16'h0300 + 16'(i), vm[i], 16'h1234, 16'h5678);
         else       drive(16'h0, 2'b00, 16'h0, 16'h0);
         tick();
         if (i > 0) begin
            if (p16 !== vp[i-1] || o16 !== vo[i-1] || t16 !== 16'h0300 + 16'(i-1))
               begin n_fail++; $display("FAIL wraphigh_%0d: got p=%h ovf=%b tag=%h expected p=%h ovf=%b", i-1, p16, o16, t16, vp[i-1], vo[i-1]); end
            n_tests++;
         end
      end
      tick();
   endtask

   task automatic test_stall();
      logic [15:0] it[7] = '{16'h1, 16'h2, 16'h3, 16'h3, 16'h3, 16'h0, 16'h0};
      logic [15:0] ia[7] = '{16'h3, 16'h7, 16'h10, 16'h10, 16'h10, 16'h0, 16'h0};
      logic [15:0] ib[7] = '{16'h5, 16'h9, 16'h10, 16'h10, 16'h10, 16'h0, 16'h0};
      logic        st[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [1:0]  es[7] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
      logic [15:0] et[7] = '{16'h0, 16'h1, 16'h1, 16'h1, 16'h2, 16'h3, 16'h0};
      logic [15:0] ep[7] = '{16'h0, 16'd15, 16'd15, 16'd15, 16'd63, 16'h100, 16'h0};
      for (int c = 0; c < 7; c++) begin
         drive(it[c], 2'b10, ia[c], ib[c]);
         stall = st[c];
         tick();
         if (s16 !== es[c] || t16 !== et[c] || p16 !== ep[c] || o16 !== 1'b0)
            begin n_fail++; $display("FAIL stall_c%0d: got st=%b tag=%h p=%h ovf=%b expected st=%b tag=%h p=%h ovf=0", c, s16, t16, p16, o16, es[c], et[c], ep[c]); end
         n_tests++;
      end
      stall = 1'b0;
   endtask

   task automatic test_flush();
      drive(16'h0041, 2'b00, 16'h0002, 16'h0003); tick();
      drive(16'h0042, 2'b00, 16'h0004, 16'h0005); tick();
      drive(16'h0043, 2'b00, 16'h0006, 16'h0007);
      flush = 1'b1; stall = 1'b1; tick();
      if (s16 !== 2'b00 || t16 !== 16'h0 || p16 !== 16'h0 || o16 !== 1'b0)
         begin n_fail++; $display("FAIL flush_stall: got st=%b tag=%h p=%h expected st=00 tag=0 p=0", s16, t16, p16); end
      n_tests++;
      flush = 1'b0; stall = 1'b0;
      drive(16'h0, 2'b00, 16'h0, 16'h0); tick();
      if (s16 !== 2'b00)
         begin n_fail++; $display("FAIL flush_after: got st=%b expected 00", s16); end
      n_tests++;
      drive(16'h0044, 2'b00, 16'h0008, 16'h0009);
      flush = 1'b1; tick();
      flush = 1'b0;
      drive(16'h0, 2'b00, 16'hFFFF, 16'hFFFF); tick();
      if (s16 !== 2'b00 || p16 !== 16'h0)
         begin n_fail++; $display("FAIL flush_issue: got st=%b p=%h expected st=00 p=0", s16, p16); end
      n_tests++;
      tick();
      if (p16 !== 16'h0 || o16 !== 1'b0 || s16 !== 2'b00)
         begin n_fail++; $display("FAIL bubble_data: got p=%h ovf=%b st=%b expected 0", p16, o16, s16); end
      n_tests++;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: case ($urandom_range(0, 2))
               0: return 32'h80;
               1: return 32'h8000;
               default: return 32'h8000_0000;
            endcase
         default: return $urandom;
      endcase
   endfunction

   task automatic test_param_sweep();
      int          wid[3] = '{8, 16, 32};
      logic [31:0] now_p[3], prev_p[3], got_p[3];
      logic        now_o[3], prev_o[3], got_o[3];
      logic [15:0] got_t[3];
      logic [1:0]  got_s[3];
      logic [15:0] now_t, prev_t;
      logic        now_v, prev_v;
      prev_v = 1'b0; prev_t = '0;
      for (int k = 0; k < 3; k++) begin prev_p[k] = '0; prev_o[k] = 1'b0; end
      for (int i = 0; i < 10000; i++) begin
         now_v = ($urandom_range(0, 7) != 0);
         now_t = now_v ? 16'($urandom_range(1, 65535)) : 16'h0;
         instr = now_t;
         mode  = 2'($urandom_range(0, 3));
         a_in  = pick_operand();
         b_in  = pick_operand();
         for (int k = 0; k < 3; k++) begin
            ref_mul(wid[k], mode, a_in, b_in, now_p[k], now_o[k]);
            if (!now_v) begin now_p[k] = '0; now_o[k] = 1'b0; end
         end
         tick();
         got_p[0] = {24'h0, p8}; got_o[0] = o8;  got_t[0] = t8;  got_s[0] = s8;
         got_p[1] = {16'h0, p16}; got_o[1] = o16; got_t[1] = t16; got_s[1] = s16;
         got_p[2] = p32;          got_o[2] = o32; got_t[2] = t32; got_s[2] = s32;
         if (i > 0) begin
            for (int k = 0; k < 3; k++) begin
               if (got_p[k] !== prev_p[k] || got_o[k] !== prev_o[k] ||
                   got_t[k] !== prev_t || got_s[k] !== {now_v, prev_v})
                  begin n_fail++; $display("FAIL sweep_w%0d_op%0d: got p=%h ovf=%b tag=%h st=%b expected p=%h ovf=%b tag=%h st=%b", wid[k], i-1, got_p[k], got_o[k], got_t[k], got_s[k], prev_p[k], prev_o[k], prev_t, {now_v, prev_v}); end
               n_tests++;
            end
         end
         prev_v = now_v; prev_t = now_t;
         for (int k = 0; k < 3; k++) begin prev_p[k] = now_p[k]; prev_o[k] = now_o[k]; end
      end
      drive(16'h0, 2'b00, 16'h0, 16'h0);
      tick(); tick();
   endtask

   initial begin
      rst = 1'b1; instr = '0; mode = '0; a_in = '0; b_in = '0;
      stall = 1'b0; flush = 1'b0;
      #1;
      test_reset();
      test_unsigned_sat();
      test_signed_sat();
      test_wrap_high();
      test_stall();
      test_flush();
      test_param_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
